// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer: steps fixed-duration lamp phases on each
// rising edge of the divided slow clock, with side-road demand gating and flashing night mode.
module traffic_light_ctrl #(
    parameter int unsigned MAIN_GREEN_SEC = 20,
    parameter int unsigned SIDE_GREEN_SEC = 10,
    parameter int unsigned YELLOW_SEC     = 3,
    parameter int unsigned ALL_RED_SEC    = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       side_req,
    input  logic       flash_mode,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [5:0] count_sec,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_2   = 3'd5,
        FLASH       = 3'd6,
        ILLEGAL     = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    localparam logic [5:0] DUR_MAIN_GREEN = 6'(MAIN_GREEN_SEC);
    localparam logic [5:0] DUR_SIDE_GREEN = 6'(SIDE_GREEN_SEC);
    localparam logic [5:0] DUR_YELLOW     = 6'(YELLOW_SEC);
    localparam logic [5:0] DUR_ALL_RED    = 6'(ALL_RED_SEC);

    state_t     state_q, state_d;
    logic [5:0] count_q, count_d;
    logic       blink_q, blink_d;
    logic       slow_clk_q;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic       tick;

    assign tick = slow_clk & ~slow_clk_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        blink_d = blink_q;
        if (tick) begin
            if (state_q == FLASH) begin
                if (flash_mode) begin
                    blink_d = ~blink_q;
                end else begin
                    state_d = ALL_RED_2;
                    count_d = DUR_ALL_RED;
                    blink_d = 1'b0;
                end
            end else if (flash_mode) begin
                state_d = FLASH;
                count_d = '0;
                blink_d = 1'b1;
            end else if (count_q > 6'd1) begin
                count_d = count_q - 6'd1;
            end else begin
                case (state_q)
                    MAIN_GREEN: begin
                        // Without side demand, main green parks on its last second.
                        if (side_req) begin
                            state_d = MAIN_YELLOW;
                            count_d = DUR_YELLOW;
                        end else begin
                            count_d = 6'd1;
                        end
                    end
                    MAIN_YELLOW: begin
                        state_d = ALL_RED_1;
                        count_d = DUR_ALL_RED;
                    end
                    ALL_RED_1: begin
                        state_d = SIDE_GREEN;
                        count_d = DUR_SIDE_GREEN;
                    end
                    SIDE_GREEN: begin
                        state_d = SIDE_YELLOW;
                        count_d = DUR_YELLOW;
                    end
                    SIDE_YELLOW: begin
                        state_d = ALL_RED_2;
                        count_d = DUR_ALL_RED;
                    end
                    ALL_RED_2: begin
                        state_d = MAIN_GREEN;
                        count_d = DUR_MAIN_GREEN;
                    end
                    default: begin
                        state_d = ALL_RED_2;
                        count_d = DUR_ALL_RED;
                    end
                endcase
            end
        end
        // The unused code recovers on the next clock, tick or not.
        if (state_q == ILLEGAL) begin
            state_d = ALL_RED_2;
            count_d = DUR_ALL_RED;
        end
    end

    // Lamps are decoded from the next state so they register together with it.
    always_comb begin
        main_d = LAMP_RED;
        side_d = LAMP_RED;
        case (state_d)
            MAIN_GREEN:  main_d = LAMP_GREEN;
            MAIN_YELLOW: main_d = LAMP_YELLOW;
            SIDE_GREEN:  side_d = LAMP_GREEN;
            SIDE_YELLOW: side_d = LAMP_YELLOW;
            FLASH: begin
                main_d = blink_d ? LAMP_YELLOW : LAMP_OFF;
                side_d = blink_d ? LAMP_YELLOW : LAMP_OFF;
            end
            default: begin
                main_d = LAMP_RED;
                side_d = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= ALL_RED_2;
            count_q    <= DUR_ALL_RED;
            blink_q    <= 1'b0;
            slow_clk_q <= 1'b0;
            main_q     <= LAMP_RED;
            side_q     <= LAMP_RED;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            blink_q    <= blink_d;
            slow_clk_q <= slow_clk;
            main_q     <= main_d;
            side_q     <= side_d;
        end
    end

    assign main_light = main_q;
    assign side_light = side_q;
    assign count_sec  = count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios with literal expectations plus
// randomized slow clock, demand, night mode and reset against a table-driven phase model.
module tb_traffic_light_ctrl;

    localparam int MG = 4;
    localparam int SG = 3;
    localparam int YL = 2;
    localparam int AR = 1;

    localparam int         DUR      [6] = '{MG, YL, AR, SG, YL, AR};
    localparam logic [2:0] MAIN_TAB [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    localparam logic [2:0] SIDE_TAB [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       slow_clk = 1'b0;
    logic       side_req = 1'b0;
    logic       flash_mode = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [5:0] count_sec;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    traffic_light_ctrl #(
        .MAIN_GREEN_SEC(MG),
        .SIDE_GREEN_SEC(SG),
        .YELLOW_SEC    (YL),
        .ALL_RED_SEC   (AR)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .slow_clk  (slow_clk),
        .side_req  (side_req),
        .flash_mode(flash_mode),
        .main_light(main_light),
        .side_light(side_light),
        .count_sec (count_sec),
        .state     (state)
    );

    always #5 clk_in = ~clk_in;

    // Phase model: phase number 0..5 in cycle order, 6 = flashing.
    typedef struct packed {
        int   ph;
        int   cnt;
        logic blink;
        logic prev;
    } m_t;

    m_t m;

    function automatic m_t step(input m_t cur, input logic slow, input logic sreq, input logic fl);
        m_t n;
        n = cur;
        n.prev = slow;
        if (!(slow && !cur.prev)) return n;
        if (cur.ph == 6) begin
            if (fl) n.blink = !cur.blink;
            else begin
                n.ph  = 5;
                n.cnt = DUR[5];
            end
        end else if (fl) begin
            n.ph    = 6;
            n.cnt   = 0;
            n.blink = 1'b1;
        end else if (cur.cnt > 1) begin
            n.cnt = cur.cnt - 1;
        end else if (cur.ph == 0 && !sreq) begin
            n.cnt = 1;
        end else begin
            n.ph  = (cur.ph + 1) % 6;
            n.cnt = DUR[n.ph];
        end
        return n;
    endfunction

    function automatic logic [2:0] exp_main(input m_t s);
        if (s.ph == 6) return s.blink ? 3'b010 : 3'b000;
        return MAIN_TAB[s.ph];
    endfunction

    function automatic logic [2:0] exp_side(input m_t s);
        if (s.ph == 6) return s.blink ? 3'b010 : 3'b000;
        return SIDE_TAB[s.ph];
    endfunction

    always @(posedge clk_in or posedge reset) begin
        if (reset) m <= '{ph: 5, cnt: AR, blink: 1'b0, prev: 1'b0};
        else       m <= step(m, slow_clk, side_req, flash_mode);
    end

    always @(negedge clk_in) begin
        checks++;
        if (state !== 3'(m.ph) || count_sec !== 6'(m.cnt) ||
            main_light !== exp_main(m) || side_light !== exp_side(m)) begin
            errors++;
            $display("FAIL model_cmp t=%0t state=%0d req=%0d count=%0d req=%0d main=%b req=%b side=%b req=%b",
                     $time, state, m.ph, count_sec, m.cnt, main_light, exp_main(m),
                     side_light, exp_side(m));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk_in);
        slow_clk = 1'b1;
        repeat (5) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    int st_seq  [13] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
    int cnt_seq [13] = '{3, 2, 1, 2, 1, 1, 3, 2, 1, 2, 1, 1, 4};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        chk("rst_state", state, 5);
        chk("rst_count", count_sec, 1);
        chk("rst_main", main_light, 3'b100);
        chk("rst_side", side_light, 3'b100);

        side_req = 1'b1;
        do_tick();
        chk("first_tick_state", state, 0);
        chk("first_tick_count", count_sec, 4);
        chk("first_tick_main", main_light, 3'b001);

        for (int i = 0; i < 13; i++) begin
            do_tick();
            chk($sformatf("cycle_state[%0d]", i), state, st_seq[i]);
            chk($sformatf("cycle_count[%0d]", i), count_sec, cnt_seq[i]);
        end

        side_req = 1'b0;
        repeat (3) do_tick();
        chk("hold_enter_count", count_sec, 1);
        for (int i = 0; i < 10; i++) begin
            do_tick();
            chk($sformatf("hold_state[%0d]", i), state, 0);
            chk($sformatf("hold_count[%0d]", i), count_sec, 1);
        end
        side_req = 1'b1;
        do_tick();
        chk("demand_state", state, 1);
        chk("demand_count", count_sec, 2);
        chk("demand_main", main_light, 3'b010);

        repeat (3) do_tick();
        chk("side_green_state", state, 3);
        chk("side_green_count", count_sec, 3);
        flash_mode = 1'b1;
        do_tick();
        chk("flash_state", state, 6);
        chk("flash_count", count_sec, 0);
        chk("flash_main", main_light, 3'b010);
        chk("flash_side", side_light, 3'b010);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            chk($sformatf("blink_main[%0d]", i), main_light, (i % 2 == 0) ? 3'b000 : 3'b010);
            chk($sformatf("blink_side[%0d]", i), side_light, (i % 2 == 0) ? 3'b000 : 3'b010);
        end
        flash_mode = 1'b0;
        do_tick();
        chk("unflash_state", state, 5);
        chk("unflash_count", count_sec, 1);
        do_tick();
        chk("unflash_next_state", state, 0);
        chk("unflash_next_count", count_sec, 4);

        @(negedge clk_in);
        slow_clk = 1'b1;
        repeat (40) @(negedge clk_in);
        chk("long_high_count", count_sec, 3);
        slow_clk = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("long_high_after", count_sec, 3);
        slow_clk = 1'b1;
        @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("pulse_count", count_sec, 2);
        chk("pulse_state", state, 0);

        for (int k = 0; k < 30 && state != 3'd4; k++) do_tick();
        chk("reach_side_yellow", state, 4);
        @(posedge clk_in);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_state", state, 5);
        chk("async_rst_count", count_sec, 1);
        chk("async_rst_main", main_light, 3'b100);
        chk("async_rst_side", side_light, 3'b100);
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            side_req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) flash_mode = ~flash_mode;
            slow_clk = 1'b1;
            repeat ($urandom_range(1, 6)) @(negedge clk_in);
            if ($urandom_range(0, 3) == 0) side_req = ~side_req;
            slow_clk = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk_in);
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk_in);
                #3;
                reset = 1'b1;
                @(negedge clk_in);
                if ($urandom_range(0, 1) == 1) slow_clk = 1'b1;
                @(negedge clk_in);
                reset = 1'b0;
            end
        end

        @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
